// File: rtl/shift_mult_array.sv
// shift_mult_array: NUM_CH lanes of iterative shift-add multipliers whose
// enabled lane products are reduced into one sum held under a valid/ready
// handshake.
// Optional feature macro: SHIFT_MULT_ARRAY_SATURATE_EN (saturate sum_o on overflow;
// when undefined, sum_o wraps modulo 2^OUT_W).
//
// Handshake semantics: a transfer happens on a rising clock edge where the
// producer's valid and the consumer's ready are both high; valid never depends
// combinationally on ready, and once sum_vld_o rises, sum_o/ovf_o stay stable
// until the transfer edge.
module shift_mult_array #(
    parameter int A_W    = 16,
    parameter int B_W    = 4,
    parameter int NUM_CH = 8,
    parameter int OUT_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [NUM_CH*A_W-1:0] a_i,
    input  logic [NUM_CH*B_W-1:0] b_i,
    input  logic [NUM_CH-1:0]     ch_en_i,
    output logic [OUT_W-1:0]      sum_o,
    output logic                  sum_vld_o,
    input  logic                  sum_rdy_i,
    output logic                  ovf_o,
    output logic [1:0]            dbg_state_o
);

    localparam int ACC_W = A_W + B_W;
    localparam int SUM_W = ACC_W + $clog2(NUM_CH);
    localparam int CNT_W = (B_W > 1) ? $clog2(B_W) : 1;
    localparam int EXT_W = (SUM_W > OUT_W) ? SUM_W : OUT_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(B_W - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MUL    = 2'd1,
        S_REDUCE = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [A_W-1:0]     r_a   [NUM_CH];
    logic [B_W-1:0]     r_b   [NUM_CH];
    logic [ACC_W-1:0]   r_acc [NUM_CH];
    logic [NUM_CH-1:0]  r_en;
    logic [CNT_W-1:0]   r_cnt;
    logic [OUT_W-1:0]   r_sum;
    logic               r_sum_vld;
    logic               r_ovf;

    logic [SUM_W-1:0]   w_sum;
    logic [EXT_W-1:0]   w_sum_ext;
    logic [OUT_W-1:0]   w_sum_wrap;
    logic [OUT_W-1:0]   w_sum_out;
    logic               w_ovf;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: the sequence is always IDLE -> MUL -> REDUCE -> HOLD.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (in_vld)             w_state_nxt = S_MUL;
            S_MUL:    if (r_cnt == CNT_LAST)  w_state_nxt = S_REDUCE;
            S_REDUCE:                         w_state_nxt = S_HOLD;
            S_HOLD:   if (sum_rdy_i)          w_state_nxt = S_IDLE;
            default:                          w_state_nxt = S_IDLE;
        endcase
    end

    // Adder tree over enabled lanes, sized so the true sum never wraps.
    always_comb begin
        w_sum = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (r_en[k]) begin
                w_sum = w_sum + SUM_W'(r_acc[k]);
            end
        end
    end

    // Overflow means any bit at or above OUT_W is set in the full-width sum.
    always_comb begin
        w_sum_ext  = EXT_W'(w_sum);
        w_sum_wrap = w_sum_ext[OUT_W-1:0];
        w_ovf      = |(w_sum_ext >> OUT_W);
`ifdef SHIFT_MULT_ARRAY_SATURATE_EN
        w_sum_out  = w_ovf ? {OUT_W{1'b1}} : w_sum_wrap;
`else
        w_sum_out  = w_sum_wrap;
`endif
    end

    // Datapath: operand capture, one shift-add step per MUL cycle, reduce, hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_acc[k] <= '0;
            end
            r_en      <= '0;
            r_cnt     <= '0;
            r_sum     <= '0;
            r_sum_vld <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_vld) begin
                        for (int k = 0; k < NUM_CH; k++) begin
                            r_a[k]   <= a_i[k*A_W +: A_W];
                            r_b[k]   <= b_i[k*B_W +: B_W];
                            r_acc[k] <= '0;
                        end
                        r_en  <= ch_en_i;
                        r_cnt <= '0;
                    end
                end
                S_MUL: begin
                    for (int k = 0; k < NUM_CH; k++) begin
                        if (r_b[k][r_cnt]) begin
                            r_acc[k] <= r_acc[k] + (ACC_W'(r_a[k]) << r_cnt);
                        end
                    end
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                S_REDUCE: begin
                    r_sum     <= w_sum_out;
                    r_ovf     <= w_ovf;
                    r_sum_vld <= 1'b1;
                end
                S_HOLD: begin
                    if (sum_rdy_i) begin
                        r_sum_vld <= 1'b0;
                    end
                end
                default: begin
                    r_sum_vld <= 1'b0;
                end
            endcase
        end
    end

    assign in_rdy      = (r_state == S_IDLE);
    assign sum_o       = r_sum;
    assign sum_vld_o   = r_sum_vld;
    assign ovf_o       = r_ovf;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_shift_mult_array.sv
// Directed bench for shift_mult_array: a default-width instance plus an
// OUT_W=8 instance that shares all stimulus, used for the overflow case.
module tb_shift_mult_array;

    localparam int A_W = 16;
    localparam int B_W = 4;
    localparam int NUM_CH = 8;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  in_vld;
    logic                  sum_rdy_i;
    logic [NUM_CH*A_W-1:0] a_i;
    logic [NUM_CH*B_W-1:0] b_i;
    logic [NUM_CH-1:0]     ch_en_i;

    logic                  in_rdy;
    logic [31:0]           sum_o;
    logic                  sum_vld_o;
    logic                  ovf_o;
    logic [1:0]            dbg_state_o;

    logic                  in_rdy8;
    logic [7:0]            sum8_o;
    logic                  sum_vld8_o;
    logic                  ovf8_o;
    logic [1:0]            dbg_state8_o;

    int n_assert = 0;
    int n_fail   = 0;
    int lat;
    logic stray;

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    shift_mult_array #(.A_W(A_W), .B_W(B_W), .NUM_CH(NUM_CH), .OUT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy),
        .a_i(a_i), .b_i(b_i), .ch_en_i(ch_en_i),
        .sum_o(sum_o), .sum_vld_o(sum_vld_o), .sum_rdy_i(sum_rdy_i),
        .ovf_o(ovf_o), .dbg_state_o(dbg_state_o)
    );

    shift_mult_array #(.A_W(A_W), .B_W(B_W), .NUM_CH(NUM_CH), .OUT_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy8),
        .a_i(a_i), .b_i(b_i), .ch_en_i(ch_en_i),
        .sum_o(sum8_o), .sum_vld_o(sum_vld8_o), .sum_rdy_i(sum_rdy_i),
        .ovf_o(ovf8_o), .dbg_state_o(dbg_state8_o)
    );

    // scoreboard comparison
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input logic [A_W-1:0] a, input logic [B_W-1:0] b);
        for (int k = 0; k < NUM_CH; k++) begin
            a_i[k*A_W +: A_W] = a;
            b_i[k*B_W +: B_W] = b;
        end
    endtask

    task automatic accept();
        int guard;
        guard = 0;
        while (!in_rdy && guard < 40) begin
            tick();
            guard++;
        end
        if (!in_rdy) check("accept_timeout", 64'd0, 64'd1);
        in_vld = 1'b1;
        tick();
        in_vld = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!sum_vld_o && n < 40) begin
            tick();
            n++;
        end
        if (!sum_vld_o) check("valid_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_vld    = 1'b0;
        sum_rdy_i = 1'b1;
        a_i       = '0;
        b_i       = '0;
        ch_en_i   = '0;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();

        // 1: reset mid-idle
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_in_rdy", in_rdy, 1);
        check("rst_sum_vld", sum_vld_o, 0);
        check("rst_sum", sum_o, 0);
        check("rst_ovf", ovf_o, 0);

        // 2: 8 lanes of 3*5
        set_all(16'd3, 4'd5);
        ch_en_i = 8'hFF;
        accept();
        wait_valid(lat);
        check("t2_latency", lat, 5);
        check("t2_sum", sum_o, 120);
        check("t2_ovf", ovf_o, 0);
        tick();
        check("t2_vld_drop", sum_vld_o, 0);
        check("t2_in_rdy", in_rdy, 1);
        check("t2_sum_kept", sum_o, 120);

        // 3: max operands, full mask then mask 0x05
        set_all(16'hFFFF, 4'hF);
        accept();
        wait_valid(lat);
        check("t3_sum_all", sum_o, 7864200);
        check("t3_ovf_all", ovf_o, 0);
        tick();
        ch_en_i = 8'h05;
        accept();
        wait_valid(lat);
        check("t3_sum_05", sum_o, 1966050);
        tick();

        // empty mask still runs full latency and yields zero
        ch_en_i = 8'h00;
        accept();
        wait_valid(lat);
        check("en0_latency", lat, 5);
        check("en0_sum", sum_o, 0);
        check("en0_ovf", ovf_o, 0);
        tick();

        // 4: backpressure for 10 cycles with ignored in_vld pulses
        set_all(16'd3, 4'd5);
        ch_en_i   = 8'h0F;
        sum_rdy_i = 1'b0;
        accept();
        wait_valid(lat);
        check("t4_sum", sum_o, 60);
        for (int i = 0; i < 10; i++) begin
            in_vld = i[0];
            set_all(16'(i + 100), 4'hF);
            tick();
            check("t4_hold_vld", sum_vld_o, 1);
            check("t4_hold_sum", sum_o, 60);
            check("t4_hold_ovf", ovf_o, 0);
            check("t4_hold_rdy", in_rdy, 0);
        end
        in_vld    = 1'b0;
        sum_rdy_i = 1'b1;
        tick();
        check("t4_release_rdy", in_rdy, 1);
        check("t4_release_vld", sum_vld_o, 0);
        check("t4_release_sum", sum_o, 60);

        // 5: overflow on the 8-bit instance (100*3 = 300)
        set_all(16'd0, 4'd0);
        a_i[0 +: A_W] = 16'd100;
        b_i[0 +: B_W] = 4'd3;
        ch_en_i = 8'h01;
        accept();
        wait_valid(lat);
        check("t5_wide_sum", sum_o, 300);
        check("t5_wide_ovf", ovf_o, 0);
        check("t5_narrow_vld", sum_vld8_o, 1);
        check("t5_narrow_ovf", ovf8_o, 1);
`ifdef SHIFT_MULT_ARRAY_SATURATE_EN
        check("t5_narrow_sum", sum8_o, 255);
`else
        check("t5_narrow_sum", sum8_o, 44);
`endif
        tick();

        // 6: reset at the second MUL edge aborts the operation
        set_all(16'd7, 4'd9);
        ch_en_i = 8'hFF;
        accept();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t6_abort_rdy", in_rdy, 1);
        check("t6_abort_vld", sum_vld_o, 0);
        stray = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (sum_vld_o !== 1'b0) stray = 1'b1;
        end
        check("t6_no_stray_vld", stray, 0);
        set_all(16'd2, 4'd2);
        accept();
        wait_valid(lat);
        check("t6_latency", lat, 5);
        check("t6_sum", sum_o, 32);
        check("t6_ovf", ovf_o, 0);
        tick();

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
